phase_acc_bank: RTL and testbench

- Multi-channel, parametrised phase accumulator bank; successor to the single free-running accumulator.
- NUM_CH independent lanes, each adding a programmable increment every enabled cycle, with selectable wrap or saturate mode.
- Increments are written to per-channel shadow registers over a valid/ready config port and applied atomically to all lanes by a commit strobe.
- Sits between the top-level IO decode and output logic; per-lane MSB drives square-wave/PDM outputs.

---
 rtl/phase_acc_pkg.sv | 8 +
 rtl/phase_acc_lane.sv | 45 ++++
 rtl/phase_acc_bank.sv | 60 ++++++
 tb/tb_phase_acc_bank.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_acc_pkg.sv
// phase_acc_pkg: shared mode constants and channel-index width helper for the phase accumulator bank
package phase_acc_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/phase_acc_lane.sv
// phase_acc_lane: one accumulator lane with active increment and registered wrap/saturate event
module phase_acc_lane
  import phase_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int ADD_WIDTH = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync,
  input  logic                 en,
  input  logic                 commit,
  input  logic [ADD_WIDTH-1:0] commit_inc,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 wrap
);
  logic [ADD_WIDTH-1:0] active;
  logic [ACC_WIDTH:0] sum;
  assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(active);
  // The add always uses the pre-commit increment; a commit only lands for the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      active <= '0;
      wrap <= 1'b0;
    end else begin
      if (commit) active <= commit_inc;
      if (sync) begin
        acc <= '0;
        wrap <= 1'b0;
      end else if (en) begin
        if (SATURATE == MODE_SAT && sum[ACC_WIDTH]) begin
          acc <= '1;
          wrap <= ~&acc;
        end else begin
          acc <= sum[ACC_WIDTH-1:0];
          wrap <= sum[ACC_WIDTH];
        end
      end else begin
        wrap <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/phase_acc_bank.sv
// phase_acc_bank: multi-lane phase accumulator with shadowed increments and atomic commit
module phase_acc_bank
  import phase_acc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_WIDTH = 32,
  parameter int ADD_WIDTH = 16,
  parameter int SATURATE = MODE_WRAP,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CH_W-1:0]             cfg_ch,
  input  logic [ADD_WIDTH-1:0]        cfg_inc,
  output logic                        cfg_err,
  input  logic                        commit,
  input  logic                        sync,
  input  logic [NUM_CH-1:0]           en,
  output logic [NUM_CH*ACC_WIDTH-1:0] acc_out,
  output logic [NUM_CH-1:0]           msb_out,
  output logic [NUM_CH-1:0]           wrap
);
  logic [ADD_WIDTH-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic accept, ch_ok;
  assign accept = cfg_valid && cfg_ready;
  assign ch_ok = 32'(cfg_ch) < NUM_CH;
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err <= accept && !ch_ok;
      for (int i = 0; i < NUM_CH; i++) if (wr_hit[i]) shadow[i] <= cfg_inc;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign wr_hit[c] = accept && ch_ok && (cfg_ch == CH_W'(c));
    assign msb_out[c] = acc_out[c*ACC_WIDTH + ACC_WIDTH-1];
    // A write accepted alongside commit bypasses the shadow straight into the lane.
    phase_acc_lane #(
      .ACC_WIDTH(ACC_WIDTH),
      .ADD_WIDTH(ADD_WIDTH),
      .SATURATE(SATURATE)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .sync(sync),
      .en(en[c]),
      .commit(commit),
      .commit_inc(wr_hit[c] ? cfg_inc : shadow[c]),
      .acc(acc_out[c*ACC_WIDTH +: ACC_WIDTH]),
      .wrap(wrap[c])
    );
  end
endmodule

// File: tb/tb_phase_acc_bank.sv
// tb_phase_acc_bank: checks a 4-lane wrap bank and a 3-lane saturating bank driven by shared stimulus
module tb_phase_acc_bank;
  logic clk = 1'b0;
  logic rst, cfg_valid, commit, sync;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic [3:0] en;
  logic rdy0, rdy1, err0, err1;
  logic [31:0] acc0;
  logic [23:0] acc1;
  logic [3:0] msb0, wrap0;
  logic [2:0] msb1, wrap1;
  int checks = 0, errors = 0;
  int m_acc[2][4], m_sh[2][4], m_act[2][4], m_wrap[2][4], m_err[2];
  int m_rdy;

  always #5 clk = ~clk;

  phase_acc_bank #(.NUM_CH(4), .ACC_WIDTH(8), .ADD_WIDTH(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy0), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_err(err0), .commit(commit), .sync(sync), .en(en),
    .acc_out(acc0), .msb_out(msb0), .wrap(wrap0));

  phase_acc_bank #(.NUM_CH(3), .ACC_WIDTH(8), .ADD_WIDTH(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy1), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_err(err1), .commit(commit), .sync(sync), .en(en[2:0]),
    .acc_out(acc1), .msb_out(msb1), .wrap(wrap1));

  // Reference: d=0 is the 4-lane modulo bank, d=1 the 3-lane clamping bank.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int n, s;
      int ns[4];
      bit ok;
      n = d ? 3 : 4;
      ok = cfg_valid && m_rdy != 0;
      if (rst) begin
        for (int c = 0; c < 4; c++) begin
          m_acc[d][c] = 0; m_sh[d][c] = 0; m_act[d][c] = 0; m_wrap[d][c] = 0;
        end
        m_err[d] = 0;
      end else begin
        ns = m_sh[d];
        if (ok && int'(cfg_ch) < n) ns[cfg_ch] = int'(cfg_inc);
        m_err[d] = (ok && int'(cfg_ch) >= n) ? 1 : 0;
        for (int c = 0; c < n; c++) begin
          if (sync) begin
            m_acc[d][c] = 0; m_wrap[d][c] = 0;
          end else if (en[c]) begin
            s = m_acc[d][c] + m_act[d][c];
            if (s > 255) begin
              m_wrap[d][c] = (d == 0 || m_acc[d][c] != 255) ? 1 : 0;
              m_acc[d][c] = d ? 255 : s - 256;
            end else begin
              m_acc[d][c] = s; m_wrap[d][c] = 0;
            end
          end else m_wrap[d][c] = 0;
          if (commit) m_act[d][c] = ns[c];
        end
        m_sh[d] = ns;
      end
    end
    m_rdy = rst ? 0 : 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; cfg_valid = 0; commit = 0; sync = 0; en = 4'h0; cfg_ch = 0; cfg_inc = 0;
  endtask

  function automatic logic [31:0] e_acc(input int d);
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(m_acc[d][c]);
    return v;
  endfunction

  function automatic logic [3:0] e_wrap(input int d);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_wrap[d][c] != 0;
    return v;
  endfunction

  function automatic logic [3:0] e_msb(input int d);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_acc[d][c] >= 128;
    return v;
  endfunction

  task automatic test_reset();
    idle();
    rst = 1; en = 4'hF; cfg_valid = 1; cfg_ch = 0; cfg_inc = 8'h11;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (acc0 !== 32'h0 || acc1 !== 24'h0 || wrap0 !== 4'h0 || wrap1 !== 3'h0) begin
        errors++;
        $display("FAIL reset_state: acc0=%h acc1=%h wrap0=%b wrap1=%b, want zeros", acc0, acc1, wrap0, wrap1);
      end
      checks++;
      if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: rdy0=%b rdy1=%b, want 0", rdy0, rdy1);
      end
    end
    idle();
    step();
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL ready_release: rdy0=%b rdy1=%b, want 1", rdy0, rdy1);
    end
    commit = 1;
    step();
    commit = 0; en = 4'hF;
    step();
    checks++;
    if (acc0 !== 32'h0 || acc1 !== 24'h0) begin
      errors++;
      $display("FAIL reset_no_shadow: acc0=%h acc1=%h, want 0", acc0, acc1);
    end
    idle();
  endtask

  task automatic test_wrap();
    logic [7:0] ex[4] = '{8'h40, 8'h80, 8'hC0, 8'h00};
    logic [31:0] e1;
    idle();
    cfg_valid = 1; cfg_ch = 1; cfg_inc = 8'h40;
    step();
    cfg_valid = 0; commit = 1;
    step();
    commit = 0; en = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (acc0[15:8] !== ex[i] || msb0[1] !== ex[i][7] || wrap0[1] !== (i == 3)) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: acc=%h msb=%b wrap=%b, want acc=%h msb=%b wrap=%b",
                 i, acc0[15:8], msb0[1], wrap0[1], ex[i], ex[i][7], i == 3);
      end
      e1 = e_acc(1);
      checks++;
      if (acc1 !== e1[23:0] || wrap1 !== e_wrap(1)[2:0]) begin
        errors++;
        $display("FAIL wrap_sat_lane[%0d]: acc1=%h wrap1=%b, want %h %b", i, acc1, wrap1, e1[23:0], e_wrap(1)[2:0]);
      end
    end
    idle();
  endtask

  task automatic test_commit();
    idle();
    cfg_valid = 1; cfg_ch = 2; cfg_inc = 8'h10; en = 4'b0100;
    step();
    cfg_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (acc0[23:16] !== 8'h00 || acc1[23:16] !== 8'h00) begin
        errors++;
        $display("FAIL commit_hold[%0d]: acc0=%h acc1=%h, want 00", i, acc0[23:16], acc1[23:16]);
      end
    end
    cfg_valid = 1; cfg_inc = 8'h20; commit = 1;
    step();
    checks++;
    if (acc0[23:16] !== 8'h00) begin
      errors++;
      $display("FAIL commit_old_value: acc=%h, want 00", acc0[23:16]);
    end
    cfg_valid = 0; commit = 0;
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if (acc0[23:16] !== 8'(i * 32) || acc1[23:16] !== 8'(i * 32)) begin
        errors++;
        $display("FAIL commit_bypass[%0d]: acc0=%h acc1=%h, want %h", i, acc0[23:16], acc1[23:16], 8'(i * 32));
      end
    end
    idle();
  endtask

  task automatic test_saturate();
    logic [7:0] ex[4] = '{8'h70, 8'hE0, 8'hFF, 8'hFF};
    idle();
    sync = 1;
    step();
    sync = 0; cfg_valid = 1; cfg_ch = 0; cfg_inc = 8'h70; commit = 1;
    step();
    cfg_valid = 0; commit = 0; en = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (acc1[7:0] !== ex[i] || wrap1[0] !== (i == 2)) begin
        errors++;
        $display("FAIL sat_seq[%0d]: acc=%h wrap=%b, want acc=%h wrap=%b", i, acc1[7:0], wrap1[0], ex[i], i == 2);
      end
      checks++;
      if (acc0 !== e_acc(0) || wrap0 !== e_wrap(0)) begin
        errors++;
        $display("FAIL sat_wrap_bank[%0d]: acc0=%h wrap0=%b, want %h %b", i, acc0, wrap0, e_acc(0), e_wrap(0));
      end
    end
    idle();
  endtask

  task automatic test_sync();
    idle();
    sync = 1;
    step();
    sync = 0; cfg_valid = 1; cfg_ch = 3; cfg_inc = 8'h78; commit = 1;
    step();
    cfg_valid = 0; commit = 0; en = 4'b1000;
    step();
    cfg_valid = 1; cfg_inc = 8'h20; commit = 1;
    step();
    checks++;
    if (acc0[31:24] !== 8'hF0) begin
      errors++;
      $display("FAIL sync_setup: acc3=%h, want F0", acc0[31:24]);
    end
    cfg_valid = 0; commit = 0; en = 4'hF; sync = 1;
    step();
    checks++;
    if (acc0 !== 32'h0 || wrap0 !== 4'h0 || acc1 !== 24'h0 || wrap1 !== 3'h0) begin
      errors++;
      $display("FAIL sync_clear: acc0=%h wrap0=%b acc1=%h wrap1=%b, want zeros", acc0, wrap0, acc1, wrap1);
    end
    sync = 0; en = 4'b1000;
    step();
    checks++;
    if (acc0[31:24] !== 8'h20) begin
      errors++;
      $display("FAIL sync_resume: acc3=%h, want 20", acc0[31:24]);
    end
    idle();
  endtask

  task automatic test_bad_ch();
    idle();
    cfg_valid = 1; cfg_ch = 3; cfg_inc = 8'h55;
    step();
    checks++;
    if (err1 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_ch_err: err0=%b err1=%b, want 0 1", err0, err1);
    end
    cfg_valid = 0; commit = 1;
    step();
    checks++;
    if (err1 !== 1'b0) begin
      errors++;
      $display("FAIL bad_ch_pulse: err1=%b, want 0", err1);
    end
    commit = 0; sync = 1;
    step();
    sync = 0; en = 4'hF;
    step();
    checks++;
    if (acc1 !== 24'h204070 || acc0 !== 32'h55204070) begin
      errors++;
      $display("FAIL bad_ch_active: acc0=%h acc1=%h, want 55204070 204070", acc0, acc1);
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] e1;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      cfg_valid = $urandom_range(0, 1);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_inc = 8'($urandom);
      commit = ($urandom_range(0, 3) == 0);
      sync = ($urandom_range(0, 15) == 0);
      en = 4'($urandom);
      step();
      e1 = e_acc(1);
      checks++;
      if (acc0 !== e_acc(0) || wrap0 !== e_wrap(0) || msb0 !== e_msb(0)) begin
        errors++;
        $display("FAIL rnd_wrap_bank[%0d]: acc=%h wrap=%b msb=%b, want %h %b %b",
                 i, acc0, wrap0, msb0, e_acc(0), e_wrap(0), e_msb(0));
      end
      checks++;
      if (acc1 !== e1[23:0] || wrap1 !== e_wrap(1)[2:0] || msb1 !== e_msb(1)[2:0]) begin
        errors++;
        $display("FAIL rnd_sat_bank[%0d]: acc=%h wrap=%b msb=%b, want %h %b %b",
                 i, acc1, wrap1, msb1, e1[23:0], e_wrap(1)[2:0], e_msb(1)[2:0]);
      end
      checks++;
      if (rdy0 !== 1'(m_rdy) || rdy1 !== 1'(m_rdy) || err0 !== 1'(m_err[0]) || err1 !== 1'(m_err[1])) begin
        errors++;
        $display("FAIL rnd_cfg[%0d]: rdy=%b%b err=%b%b, want rdy=%0d err=%0d%0d",
                 i, rdy0, rdy1, err0, err1, m_rdy, m_err[0], m_err[1]);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_wrap();
    test_commit();
    test_saturate();
    test_sync();
    test_bad_ch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
